fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32 pipeline. Owns the fetch PC, the instruction-memory request/response handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Consumes the hazard unit's PC_write_en, IFID_write and IFID_flush, plus the EXE-stage Branch_Ctrl and redirect targets.
- Feeds the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- XLEN, 32, address and instruction width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- PC_write_en  in  1  0 = load-use stall; no new fetch is issued
- IFID_write  in  1  0 = hold the IF/ID register
- IFID_flush  in  1  1 = load a bubble into IF/ID
- Branch_Ctrl  in  2  00 = sequential; 01 = branch target; 10 or 11 = jalr target
- pc_branch  in  XLEN  branch/jal target from EXE
- pc_jalr  in  XLEN  jalr target from EXE, bit 0 already cleared
- im_req  out  1  fetch request
- im_addr  out  XLEN  fetch address, equal to the fetch PC
- im_gnt  in  1  request accepted this cycle
- im_rvalid  in  1  response valid; at most one outstanding, earliest one cycle after grant
- im_rdata  in  XLEN  instruction word
- IFID_pc  out  XLEN  PC of the instruction in IF/ID
- IFID_inst  out  XLEN  instruction in IF/ID
- IFID_valid  out  1  1 = IF/ID holds a real instruction
- fetch_busy  out  1  1 = a request is outstanding (state WAIT or KILL)

Behaviour:
- Reset: next clk edge with rst=1 gives:
  - fpc=RESET_PC, state IDLE, skid buffer empty
  - IFID_pc=0, IFID_inst=32'h0000_0013 (NOP), IFID_valid=0
  - im_req=0 during the reset cycle
  - A reset mid-transaction abandons the outstanding fetch; any im_rvalid after reset, before the next grant, is ignored.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: one outstanding request; response will be used.
  - KILL: one outstanding request; response will be dropped.
- Transitions:
  - IDLE -> WAIT on grant.
  - WAIT -> IDLE on im_rvalid with no same-cycle grant; WAIT -> WAIT on im_rvalid with a same-cycle grant.
  - WAIT -> KILL on redirect without im_rvalid.
  - KILL -> IDLE on im_rvalid.
- im_req=1 when all of the following hold:
  - !rst and PC_write_en and Branch_Ctrl==00
  - skid buffer empty, or draining this cycle
  - state is IDLE, or state is WAIT with im_rvalid this cycle
- Grant (im_req & im_gnt): req_pc <= fpc; fpc <= fpc+4, wrapping mod 2^32.
- Redirect (Branch_Ctrl!=00):
  - fpc <= pc_branch (01) or pc_jalr (10/11).
  - Skid buffer cleared. A response arriving the same cycle is discarded.
  - An outstanding request without a same-cycle response moves to KILL.
  - No request is issued in the redirect cycle.
  - A redirect while already in KILL updates fpc only.
- Response delivery (WAIT and im_rvalid, no redirect): entry is {req_pc, im_rdata}.
- IF/ID update priority: rst > IFID_flush > IFID_write > hold.
  - Flush loads the bubble {0, NOP, 0}.
  - Write loads the skid entry if present; else the same-cycle response; else the bubble.
  - Hold keeps IF/ID unchanged.
- Skid buffer capacity is one entry.
  - It fills when a response arrives while IF/ID is held (IFID_write=0, no flush).
  - It also fills when IF/ID loads a buffered entry while a new response arrives the same cycle.
  - It empties when IF/ID loads from it.
  - A response never arrives while the buffer is full and not draining, because the request gating prevents it.
- Instruction order is strictly preserved; no instruction is duplicated or lost across stalls.

Optional Feature:
- Macro FETCH_PERF_EN. When defined, add the following, each cleared on rst and saturating at all-ones:
  - output perf_fetch_wait_cycles [31:0]: increments each cycle fetch_busy=1 and im_rvalid=0
  - output perf_redirects [31:0]: increments each redirect cycle
- When undefined, these ports and counters do not exist.

Decomposition:
- Shared package (cpu_pkg): NOP_INST constant; Branch_Ctrl enum (BR_NONE, BR_BRANCH, BR_JALR); fetch FSM enum (F_IDLE, F_WAIT, F_KILL); XLEN.
- Sub-module fetch_skid_buf: one-entry {pc, inst} buffer with push/pop/clear and full flag.

Test Plan:
- Reset release, imem granting every cycle with 1-cycle latency -> im_addr sequence 0,4,8,...; IFID_pc follows 0,4,8 one cycle after each response; IFID_valid=1 from the first response.
- IFID_write=0 and PC_write_en=0 for 1 cycle while the response for pc 0x10 arrives -> entry buffered; the next cycle IF/ID loads 0x10; no gap or duplicate; im_req=0 during the stall.
- Branch_Ctrl=01, pc_branch=0x200, with a request outstanding and no response -> state KILL; the late response for the old PC is dropped; next im_addr=0x200; IF/ID bubble for that cycle when IFID_flush=1.
- Branch_Ctrl=10, pc_jalr=0x84, coinciding with im_rvalid -> response discarded; state IDLE; next fetch at 0x84.
- fpc=32'hFFFF_FFFC granted -> next im_addr=0x0.
- rst asserted in WAIT, im_rvalid the next cycle -> ignored; IF/ID stays the bubble; first fetch from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline types and constants.
// Used by the fetch stage and its skid buffer.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_BRANCH = 2'b01,
    BR_JALR   = 2'b10
  } br_ctrl_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_KILL = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding buffer for the fetch stage.
// Clear beats push, push beats pop.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] inst_i,
  output logic         full_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] inst_o
);

  logic         full_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] inst_q;

  // occupancy and payload of the single entry
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= W'(NOP_INST);
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch PC, imem handshake, skid buffer, IF/ID register.
// Optional FETCH_PERF_EN adds saturating wait/redirect counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_write_en,
  input  logic            IFID_write,
  input  logic            IFID_flush,
  input  logic [1:0]      Branch_Ctrl,
  input  logic [XLEN-1:0] pc_branch,
  input  logic [XLEN-1:0] pc_jalr,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [XLEN-1:0] im_rdata,
  output logic [XLEN-1:0] IFID_pc,
  output logic [XLEN-1:0] IFID_inst,
  output logic            IFID_valid,
  output logic            fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_wait_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fpc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [XLEN-1:0] ifid_inst_q;
  logic            ifid_valid_q;

  logic            redirect;
  logic [XLEN-1:0] tgt;
  logic            ifid_ld;
  logic            drain;
  logic            rsp_ok;
  logic            push;
  logic            grant;
  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  assign redirect = (Branch_Ctrl != BR_NONE);
  assign tgt      = (Branch_Ctrl == BR_BRANCH)
                  ? pc_branch : pc_jalr;
  assign ifid_ld  = !rst && !IFID_flush && IFID_write;
  assign drain    = ifid_ld && skid_full;
  assign rsp_ok   = (state_q == F_WAIT) && im_rvalid
                 && !redirect;
  assign push     = rsp_ok
                 && ((!IFID_write && !IFID_flush) || drain);

  assign im_req = !rst && PC_write_en && !redirect
               && (!skid_full || drain)
               && ((state_q == F_IDLE)
                || ((state_q == F_WAIT) && im_rvalid));
  assign grant      = im_req && im_gnt;
  assign im_addr    = fpc_q;
  assign fetch_busy = (state_q != F_IDLE);

  fetch_skid_buf #(.W(XLEN)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect),
    .push_i  (push),
    .pop_i   (drain),
    .pc_i    (req_pc_q),
    .inst_i  (im_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  // fetch PC and request-tracking FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= F_IDLE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (redirect)
        fpc_q <= tgt;
      else if (grant)
        fpc_q <= fpc_q + XLEN'(4);
      if (grant)
        req_pc_q <= fpc_q;
      unique case (state_q)
        F_IDLE: if (grant) state_q <= F_WAIT;
        F_WAIT: begin
          if (im_rvalid)
            state_q <= grant ? F_WAIT : F_IDLE;
          else if (redirect)
            state_q <= F_KILL;
        end
        F_KILL: if (im_rvalid) state_q <= F_IDLE;
        default: state_q <= F_IDLE;
      endcase
    end
  end

  // IF/ID register: flush > write > hold
  always_ff @(posedge clk) begin
    if (rst || IFID_flush) begin
      ifid_pc_q    <= '0;
      ifid_inst_q  <= XLEN'(NOP_INST);
      ifid_valid_q <= 1'b0;
    end else if (IFID_write) begin
      if (skid_full) begin
        ifid_pc_q    <= skid_pc;
        ifid_inst_q  <= skid_inst;
        ifid_valid_q <= 1'b1;
      end else if (rsp_ok) begin
        ifid_pc_q    <= req_pc_q;
        ifid_inst_q  <= im_rdata;
        ifid_valid_q <= 1'b1;
      end else begin
        ifid_pc_q    <= '0;
        ifid_inst_q  <= XLEN'(NOP_INST);
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign IFID_pc    = ifid_pc_q;
  assign IFID_inst  = ifid_inst_q;
  assign IFID_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] wait_q;
  logic [31:0] redir_q;

  // saturating stall and redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      redir_q <= '0;
    end else begin
      if (fetch_busy && !im_rvalid && !(&wait_q))
        wait_q <= wait_q + 32'd1;
      if (redirect && !(&redir_q))
        redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_fetch_wait_cycles = wait_q;
  assign perf_redirects         = redir_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
// Imem model with per-grant latency; monitor checks IF/ID stream.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        PC_write_en;
  logic        IFID_write;
  logic        IFID_flush;
  logic [1:0]  Branch_Ctrl;
  logic [31:0] pc_branch;
  logic [31:0] pc_jalr;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_inst;
  logic        IFID_valid;
  logic        fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_wait_cycles;
  logic [31:0] perf_redirects;
`endif

  fetch_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_write_en (PC_write_en),
    .IFID_write  (IFID_write),
    .IFID_flush  (IFID_flush),
    .Branch_Ctrl (Branch_Ctrl),
    .pc_branch   (pc_branch),
    .pc_jalr     (pc_jalr),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_gnt      (im_gnt),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .IFID_pc     (IFID_pc),
    .IFID_inst   (IFID_inst),
    .IFID_valid  (IFID_valid),
    .fetch_busy  (fetch_busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_wait_cycles (perf_fetch_wait_cycles),
    .perf_redirects         (perf_redirects)
`endif
  );

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h0BAD_0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, want, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, ins(pc)});
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // imem: samples grants at negedge, answers lat cycles later
  initial begin
    logic        g;
    logic [31:0] ga;
    logic        pend;
    logic [31:0] pa;
    int          cnt;
    im_rvalid = 1'b0;
    im_rdata  = '0;
    pend      = 1'b0;
    pa        = '0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      g  = im_req && im_gnt;
      ga = im_addr;
      @(posedge clk);
      #2;
      if (im_rvalid) begin
        im_rvalid = 1'b0;
        pend      = 1'b0;
      end
      if (g) begin
        pend = 1'b1;
        cnt  = lat;
        pa   = ga;
      end
      if (pend && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = ins(pa);
        end
      end
    end
  end

  // monitor: after every accepting IF/ID write, a valid
  // entry must be the next expected instruction
  initial begin
    logic        wr;
    logic [63:0] e;
    wr = 1'b0;
    forever begin
      @(negedge clk);
      if (wr && IFID_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ifid_extra: got pc %h want none",
                   IFID_pc);
        end else begin
          e = exp_q.pop_front();
          if ({IFID_pc, IFID_inst} !== e) begin
            bad++;
            $display("FAIL ifid_seq: got %h/%h want %h/%h",
                     IFID_pc, IFID_inst, e[63:32], e[31:0]);
          end
        end
      end
      wr = IFID_write && !IFID_flush && !rst;
    end
  end

  initial begin
    rst         = 1'b1;
    PC_write_en = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    Branch_Ctrl = 2'b00;
    pc_branch   = '0;
    pc_jalr     = '0;
    im_gnt      = 1'b1;
    nx();
    nx();
    @(negedge clk);
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_pc", IFID_pc, 32'h0);
    chk("rst_inst", IFID_inst, 32'h0000_0013);
    chk("rst_valid", {31'b0, IFID_valid}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);

    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    nx();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq_req", {31'b0, im_req}, 32'd1);
      chk("seq_addr", im_addr, 32'(i * 4));
      if (i == 2) begin
        chk("seq_valid", {31'b0, IFID_valid}, 32'd1);
        chk("seq_busy", {31'b0, fetch_busy}, 32'd1);
      end
      nx();
    end

    IFID_write  = 1'b0;
    PC_write_en = 1'b0;
    @(negedge clk);
    chk("stall_req", {31'b0, im_req}, 32'd0);
    chk("stall_pc", IFID_pc, 32'h0C);
    nx();
    IFID_write  = 1'b1;
    PC_write_en = 1'b1;
    @(negedge clk);
    chk("drain_req", {31'b0, im_req}, 32'd1);
    chk("drain_addr", im_addr, 32'h14);
    chk("hold_pc", IFID_pc, 32'h0C);
    nx();
    @(negedge clk);
    chk("skid_pc", IFID_pc, 32'h10);
    chk("next_addr", im_addr, 32'h18);
    nx();

    lat         = 3;
    Branch_Ctrl = 2'b01;
    pc_branch   = 32'h200;
    IFID_flush  = 1'b1;
    @(negedge clk);
    chk("br_busy", {31'b0, fetch_busy}, 32'd1);
    chk("br_req", {31'b0, im_req}, 32'd0);
    nx();
    Branch_Ctrl = 2'b00;
    IFID_flush  = 1'b0;
    @(negedge clk);
    chk("kill_busy", {31'b0, fetch_busy}, 32'd1);
    chk("kill_req", {31'b0, im_req}, 32'd0);
    chk("flush_valid", {31'b0, IFID_valid}, 32'd0);
    nx();
    lat = 1;
    @(negedge clk);
    chk("kill_rsp_req", {31'b0, im_req}, 32'd0);
    nx();
    @(negedge clk);
    chk("br_addr", im_addr, 32'h200);
    chk("br_req2", {31'b0, im_req}, 32'd1);
    chk("drop_valid", {31'b0, IFID_valid}, 32'd0);
    nx();

    expect_pc(32'h84);
    expect_pc(32'h88);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    Branch_Ctrl = 2'b10;
    pc_jalr     = 32'h84;
    @(negedge clk);
    chk("jalr_req", {31'b0, im_req}, 32'd0);
    nx();
    Branch_Ctrl = 2'b00;
    @(negedge clk);
    chk("jalr_busy", {31'b0, fetch_busy}, 32'd0);
    chk("jalr_addr", im_addr, 32'h84);
    chk("jalr_valid", {31'b0, IFID_valid}, 32'd0);
    nx();
    @(negedge clk);
    chk("jalr_next", im_addr, 32'h88);
    nx();
    PC_write_en = 1'b0;
    @(negedge clk);
    chk("pcw_req", {31'b0, im_req}, 32'd0);
    nx();
    PC_write_en = 1'b1;
    Branch_Ctrl = 2'b01;
    pc_branch   = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("idle_br_req", {31'b0, im_req}, 32'd0);
    nx();
    Branch_Ctrl = 2'b00;
    @(negedge clk);
    chk("top_addr", im_addr, 32'hFFFF_FFFC);
    nx();
    @(negedge clk);
    chk("wrap_addr", im_addr, 32'h0);
    nx();
    @(negedge clk);
    chk("wrap_next", im_addr, 32'h4);
    nx();

    rst = 1'b1;
    lat = 2;
    @(negedge clk);
    chk("mid_rst_req", {31'b0, im_req}, 32'd0);
    nx();
    expect_pc(32'h0);
    expect_pc(32'h4);
    rst = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("post_rst_addr", im_addr, 32'h0);
    chk("post_rst_req", {31'b0, im_req}, 32'd1);
    chk("post_rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("post_rst_vld", {31'b0, IFID_valid}, 32'd0);
    nx();
    @(negedge clk);
    chk("stale_vld", {31'b0, IFID_valid}, 32'd0);
    chk("post_rst_a4", im_addr, 32'h4);
    nx();
    PC_write_en = 1'b0;
    @(negedge clk);
    chk("end_req", {31'b0, im_req}, 32'd0);
    nx();
    nx();
    nx();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
